// File: rtl/axi4lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NUM_REQ requesters,
// one transaction in flight, with a per-transaction completion timeout.
//
// state    | meaning
// S_IDLE   | searching req_valid from rr_ptr for the next requester
// S_WR_AW_W| awvalid/wvalid driven, each drops after its own handshake
// S_WR_B   | bready driven, waiting for bvalid
// S_RD_AR  | arvalid driven, waiting for arready
// S_RD_R   | rready driven, waiting for rvalid
// S_DONE   | req_done pulse for the granted requester, rr_ptr advances
module axi4lite_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_rnw,
   input  logic [2*NUM_REQ-1:0]      req_size,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_status,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [ADDR_W-1:0]         m_awaddr,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   output logic [DATA_W-1:0]         m_wdata,
   output logic [3:0]                m_wstrb,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   input  logic [1:0]                m_bresp,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   output logic [ADDR_W-1:0]         m_araddr,
   input  logic                      m_rvalid,
   output logic                      m_rready,
   input  logic [DATA_W-1:0]         m_rdata,
   input  logic [1:0]                m_rresp
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [NUM_REQ-1:0]  req_done_q, req_done_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]          rsp_resp_q, rsp_resp_d;
   logic                rsp_status_q, rsp_status_d;

   logic                gnt_found;
   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_rnw;
   logic [1:0]          gnt_size;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [DATA_W-1:0]   gnt_wdata;

   function automatic logic [IDX_W-1:0] wrap_idx(input int v);
      return IDX_W'(v % NUM_REQ);
   endfunction

   // Byte lanes come from the low address bits; a misaligned halfword keeps only addr[1].
   function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'd0:    return 4'b0001 << a;
         2'd1:    return 4'b0011 << {a[1], 1'b0};
         default: return 4'hF;
      endcase
   endfunction

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && req_valid[wrap_idx(int'(rr_ptr_q) + i)]) begin
            gnt_found = 1'b1;
            gnt_idx   = wrap_idx(int'(rr_ptr_q) + i);
         end
      end
      gnt_rnw   = req_rnw[gnt_idx];
      gnt_size  = req_size[2*gnt_idx +: 2];
      gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      gnt_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      awaddr_d     = awaddr_q;
      araddr_d     = araddr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      req_done_d   = '0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_resp_d   = rsp_resp_q;
      rsp_status_d = rsp_status_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               idx_d = gnt_idx;
               cnt_d = '0;
               if (gnt_rnw) begin
                  state_d   = S_RD_AR;
                  arvalid_d = 1'b1;
                  araddr_d  = gnt_addr;
               end else begin
                  state_d   = S_WR_AW_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = gnt_addr;
                  wdata_d   = gnt_wdata;
                  wstrb_d   = strb_of(gnt_size, gnt_addr[1:0]);
               end
            end
         end
         S_WR_AW_W: begin
            if (awvalid_q && m_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = S_WR_B;
               bready_d = 1'b1;
            end
         end
         S_WR_B: begin
            if (m_bvalid) begin
               state_d             = S_DONE;
               bready_d            = 1'b0;
               rsp_rdata_d         = '0;
               rsp_resp_d          = m_bresp;
               rsp_status_d        = 1'b0;
               req_done_d[idx_q]   = 1'b1;
            end
         end
         S_RD_AR: begin
            if (m_arready) begin
               state_d   = S_RD_R;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         S_RD_R: begin
            if (m_rvalid) begin
               state_d             = S_DONE;
               rready_d            = 1'b0;
               rsp_rdata_d         = m_rdata;
               rsp_resp_d          = m_rresp;
               rsp_status_d        = 1'b0;
               req_done_d[idx_q]   = 1'b1;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Timeout wins over a handshake landing in the same cycle.
      if (state_q != S_IDLE && state_q != S_DONE) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d           = S_DONE;
            awvalid_d         = 1'b0;
            wvalid_d          = 1'b0;
            bready_d          = 1'b0;
            arvalid_d         = 1'b0;
            rready_d          = 1'b0;
            rsp_rdata_d       = '0;
            rsp_resp_d        = 2'b00;
            rsp_status_d      = 1'b1;
            req_done_d        = '0;
            req_done_d[idx_q] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         rr_ptr_q     <= '0;
         cnt_q        <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awaddr_q     <= '0;
         araddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         req_done_q   <= '0;
         rsp_rdata_q  <= '0;
         rsp_resp_q   <= '0;
         rsp_status_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         awaddr_q     <= awaddr_d;
         araddr_q     <= araddr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         req_done_q   <= req_done_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_resp_q   <= rsp_resp_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   assign m_awvalid  = awvalid_q;
   assign m_wvalid   = wvalid_q;
   assign m_bready   = bready_q;
   assign m_arvalid  = arvalid_q;
   assign m_rready   = rready_q;
   assign m_awaddr   = awaddr_q;
   assign m_araddr   = araddr_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign req_done   = req_done_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_resp   = rsp_resp_q;
   assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Scoreboard bench for axi4lite_req_arbiter: stimulus pushes expected AW/W/AR beats and
// completions; a configurable slave and a completion monitor pop and compare.
module tb_axi4lite_req_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_rnw = '0;
   logic [2*NR-1:0] req_size = '0;
   logic [AW*NR-1:0] req_addr = '0;
   logic [DW*NR-1:0] req_wdata = '0;
   logic [NR-1:0]   req_done;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            rsp_status;
   logic            m_awvalid, m_awready;
   logic [AW-1:0]   m_awaddr;
   logic            m_wvalid, m_wready;
   logic [DW-1:0]   m_wdata;
   logic [3:0]      m_wstrb;
   logic            m_bvalid, m_bready;
   logic [1:0]      m_bresp;
   logic            m_arvalid, m_arready;
   logic [AW-1:0]   m_araddr;
   logic            m_rvalid, m_rready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;

   axi4lite_req_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rnw(req_rnw), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_status(rsp_status),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NR-1:0] onehot;
      logic [31:0]   rdata;
      logic [1:0]    resp;
      logic          status;
   } done_t;

   done_t       done_q[$];
   logic [31:0] aw_q[$];
   logic [35:0] w_q[$];
   logic [31:0] ar_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   // slave configuration, written by stimulus
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   bit          aw_never = 0;
   logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   logic [31:0] r_data_cfg = '0;
   int          ar_unstable = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // slave: decides ready/valid at each negedge; a *_pend beat completes at the next posedge
   initial begin
      bit aw_pend = 0, w_pend = 0, b_pend = 0, ar_pend = 0, r_pend = 0;
      bit aw_done = 0, w_done = 0, ar_done = 0, ar_watch = 0;
      int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
      logic [31:0] ar_prev = '0;
      logic [63:0] e;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
            aw_done = 0; w_done = 0; ar_done = 0; ar_watch = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
         end else begin
            if (aw_pend) aw_done = 1;
            if (w_pend)  w_done = 1;
            if (ar_pend) ar_done = 1;
            if (b_pend) begin m_bvalid = 0; aw_done = 0; w_done = 0; b_cnt = 0; end
            if (r_pend) begin m_rvalid = 0; ar_done = 0; r_cnt = 0; end
            if (ar_watch && (!m_arvalid || m_araddr !== ar_prev)) ar_unstable++;

            if (m_awvalid && !aw_done) begin
               aw_cnt++; m_awready = !aw_never && (aw_cnt > aw_dly);
            end else begin aw_cnt = 0; m_awready = 0; end
            if (m_wvalid && !w_done) begin
               w_cnt++; m_wready = (w_cnt > w_dly);
            end else begin w_cnt = 0; m_wready = 0; end
            if (m_arvalid && !ar_done) begin
               ar_cnt++; m_arready = (ar_cnt > ar_dly);
            end else begin ar_cnt = 0; m_arready = 0; end
            if (aw_done && w_done && m_bready && !m_bvalid) begin
               b_cnt++;
               if (b_cnt > b_dly) begin m_bvalid = 1; m_bresp = b_resp_cfg; end
            end
            if (ar_done && m_rready && !m_rvalid) begin
               r_cnt++;
               if (r_cnt > r_dly) begin m_rvalid = 1; m_rdata = r_data_cfg; m_rresp = r_resp_cfg; end
            end

            aw_pend = m_awvalid && m_awready;
            w_pend  = m_wvalid && m_wready;
            ar_pend = m_arvalid && m_arready;
            b_pend  = m_bvalid && m_bready;
            r_pend  = m_rvalid && m_rready;
            ar_watch = m_arvalid && !ar_pend;
            ar_prev  = m_araddr;

            if (aw_pend) begin
               e = 'x; if (aw_q.size() > 0) e = {32'h0, aw_q.pop_front()};
               chk("aw_addr", {32'h0, m_awaddr}, e);
            end
            if (w_pend) begin
               e = 'x; if (w_q.size() > 0) e = {28'h0, w_q.pop_front()};
               chk("w_strb_data", {28'h0, m_wstrb, m_wdata}, e);
            end
            if (ar_pend) begin
               e = 'x; if (ar_q.size() > 0) e = {32'h0, ar_q.pop_front()};
               chk("ar_addr", {32'h0, m_araddr}, e);
            end
         end
      end
   end

   // completion monitor
   initial begin
      done_t e;
      forever begin
         @(negedge clk);
         if (req_done !== '0) begin
            e = 'x;
            if (done_q.size() > 0) e = done_q.pop_front();
            chk("done_onehot", {60'h0, req_done}, {60'h0, e.onehot});
            chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
            chk("rsp_resp_status", {61'h0, rsp_resp, rsp_status}, {61'h0, e.resp, e.status});
            chk("done_channels_idle", {59'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'h0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input int i, input bit rnw, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
      req_rnw[i] = rnw;
      req_size[2*i +: 2] = sz;
      req_addr[AW*i +: AW] = a;
      req_wdata[DW*i +: DW] = d;
   endtask

   task automatic exp_write(input int i, input logic [31:0] a, input logic [3:0] strb,
                            input logic [31:0] d, input logic [1:0] bresp);
      aw_q.push_back(a);
      w_q.push_back({strb, d});
      done_q.push_back({NR'(1 << i), 32'h0, bresp, 1'b0});
   endtask

   task automatic exp_read(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] rresp);
      ar_q.push_back(a);
      done_q.push_back({NR'(1 << i), d, rresp, 1'b0});
   endtask

   // releases each requester on its req_done; cyc = negedges waited
   task automatic drain(output int cyc);
      cyc = 0;
      while (req_valid != '0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         req_valid = req_valid & ~req_done;
      end
      if (req_valid != '0) chk("drain_budget", {60'h0, req_valid}, 64'h0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      chk(name, {16'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_done,
                 rsp_status, rsp_resp, m_wstrb,
                 m_awaddr | m_araddr | m_wdata | rsp_rdata}, 64'h0);
   endtask

   task automatic do_reset();
      rst = 1; req_valid = '0;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
   endtask

   initial begin
      int c;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_outputs");
      rst = 0;
      @(negedge clk);

      // T1: single write, slave always ready
      set_req(0, 0, 2'd2, 32'h10, 32'hDEADBEEF);
      exp_write(0, 32'h10, 4'hF, 32'hDEADBEEF, 2'b00);
      req_valid = 4'b0001;
      drain(c);
      chk("t1_latency", c, 3);

      // T2: round-robin order
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 0, 2'd2, 32'h100 + 32'(4*i), 32'hA0 + 32'(i));
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++) exp_write(i, 32'h100 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 2'b00);
         req_valid = 4'b1111;
         drain(c);
      end
      exp_write(2, 32'h108, 4'hF, 32'hA2, 2'b00);
      req_valid = 4'b0100;
      drain(c);
      exp_write(3, 32'h10C, 4'hF, 32'hA3, 2'b00);
      exp_write(0, 32'h100, 4'hF, 32'hA0, 2'b00);
      exp_write(1, 32'h104, 4'hF, 32'hA1, 2'b00);
      exp_write(2, 32'h108, 4'hF, 32'hA2, 2'b00);
      req_valid = 4'b1111;
      drain(c);

      // T3: strobe derivation
      set_req(1, 0, 2'd0, 32'h3, 32'hAA000000); exp_write(1, 32'h3, 4'h8, 32'hAA000000, 2'b00);
      req_valid = 4'b0010; drain(c);
      set_req(2, 0, 2'd1, 32'h2, 32'hBBBB0000); exp_write(2, 32'h2, 4'hC, 32'hBBBB0000, 2'b00);
      req_valid = 4'b0100; drain(c);
      set_req(3, 0, 2'd3, 32'h4, 32'h11223344); exp_write(3, 32'h4, 4'hF, 32'h11223344, 2'b00);
      req_valid = 4'b1000; drain(c);
      set_req(0, 0, 2'd0, 32'h1, 32'h0000DD00); exp_write(0, 32'h1, 4'h2, 32'h0000DD00, 2'b00);
      req_valid = 4'b0001; drain(c);
      set_req(1, 0, 2'd1, 32'h3, 32'hCCCC0000); exp_write(1, 32'h3, 4'hC, 32'hCCCC0000, 2'b00);
      req_valid = 4'b0010; drain(c);

      // T4: delayed read
      ar_dly = 3; r_dly = 5; r_data_cfg = 32'h12345678; r_resp_cfg = 2'b10;
      set_req(1, 1, 2'd0, 32'h20, 32'h0);
      exp_read(1, 32'h20, 32'h12345678, 2'b10);
      req_valid = 4'b0010;
      drain(c);
      chk("t4_arvalid_stable", ar_unstable, 0);
      ar_dly = 0; r_dly = 0;

      // T5: awready never comes -> timeout
      aw_never = 1;
      set_req(0, 0, 2'd2, 32'h40, 32'h55);
      w_q.push_back({4'hF, 32'h55});
      done_q.push_back({NR'(1), 32'h0, 2'b00, 1'b1});
      req_valid = 4'b0001;
      drain(c);
      chk("t5_timeout_latency", c, TO + 1);
      aw_never = 0;
      do_reset();
      aw_dly = 3; w_dly = 0; b_resp_cfg = 2'b01;
      set_req(2, 0, 2'd2, 32'h44, 32'h66);
      exp_write(2, 32'h44, 4'hF, 32'h66, 2'b01);
      req_valid = 4'b0100;
      drain(c);
      aw_dly = 0; b_resp_cfg = 2'b00;

      // T6: reset while waiting in WR_B
      b_dly = 20;
      set_req(0, 0, 2'd2, 32'h80, 32'h77);
      aw_q.push_back(32'h80);
      w_q.push_back({4'hF, 32'h77});
      req_valid = 4'b0001;
      repeat (2) @(negedge clk);
      chk("t6_in_wr_b", {63'h0, m_bready}, 64'h1);
      rst = 1; req_valid = '0;
      @(negedge clk);
      check_reset_outputs("t6_reset_outputs");
      repeat (2) @(negedge clk);
      rst = 0; b_dly = 0;
      @(negedge clk);
      r_data_cfg = 32'hCAFEF00D; r_resp_cfg = 2'b00;
      set_req(1, 1, 2'd2, 32'h30, 32'h0);
      exp_read(1, 32'h30, 32'hCAFEF00D, 2'b00);
      req_valid = 4'b0010;
      drain(c);

      repeat (2) @(negedge clk);
      chk("sb_done_empty", done_q.size(), 0);
      chk("sb_aw_empty", aw_q.size(), 0);
      chk("sb_w_empty", w_q.size(), 0);
      chk("sb_ar_empty", ar_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
